txshift: RTL

TXSHIFT -- requirements
Module: txshift

---
 rtl/txshift.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/txshift.sv
// txshift: byte-wide serial transmitter with a free-running 50% duty bit clock.
// Frame: start(0), data bits 0..7 LSB first, optional even parity, stop(1).
// Ports:
//   i_Pclk       sole clock, rising edge
//   i_Rst_n      synchronous active-low reset
//   i_Enable     permits acceptance of new frames
//   i_Tx_Start   send request, sampled every cycle
//   i_Tx_Data    byte to send
//   o_Bclk       bit clock to the link partner (high for the first half bit)
//   o_Tx_Serial  serial line, idle high, changes only on o_Bclk rising
//   o_Busy       high from acceptance until the end of the stop bit
//   o_Done       one-cycle pulse in the final cycle of the stop bit
// Build option: define TXSHIFT_PARITY_EN to add an even-parity bit (11-bit frame).
module txshift #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_Pclk,
    input  logic       i_Rst_n,
    input  logic       i_Enable,
    input  logic       i_Tx_Start,
    input  logic [7:0] i_Tx_Data,
    output logic       o_Bclk,
    output logic       o_Tx_Serial,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

`ifdef TXSHIFT_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    buf_q, buf_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic wrap;
    logic stop_end;
    logic accept;

    always_ff @(posedge i_Pclk) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Last cycle of a bit period: the line updates on the following edge,
    // which is exactly when o_Bclk rises.
    assign wrap     = (cnt_q == LAST);
    assign stop_end = (state_q == STOP) && wrap;

    // Busy drops in the final stop cycle so a request seen then can go
    // straight into the next start bit without an idle bit in between.
    assign o_Busy      = busy_q && !stop_end;
    assign o_Done      = stop_end;
    assign o_Bclk      = (cnt_q < HALF);
    assign o_Tx_Serial = tx_q;
    assign accept      = i_Tx_Start && i_Enable && !o_Busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        buf_d   = buf_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        if (accept) begin
            buf_d  = i_Tx_Data;
            busy_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // busy_q (not accept) gates this, so a request landing on
                // a wrap cycle waits for the following wrap.
                if (wrap && busy_q) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = buf_q[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (idx_q == 3'd7) begin
`ifdef TXSHIFT_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^buf_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = buf_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef TXSHIFT_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (wrap) begin
                    if (accept) begin
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
